// File: rtl/sec32_pkg.sv
// Shared constants, code-column table and encoder for the 32-bit SEC corrector.
package sec32_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CHK_W  = 8;

  // Column j: bit (j mod 4) plus one nibble-4 bit (groups 0-3) or three nibble-4 bits (groups 4-7)
  localparam logic [CHK_W-1:0] COL [0:DATA_W-1] = '{
    8'h11, 8'h12, 8'h14, 8'h18,
    8'h21, 8'h22, 8'h24, 8'h28,
    8'h41, 8'h42, 8'h44, 8'h48,
    8'h81, 8'h82, 8'h84, 8'h88,
    8'hE1, 8'hE2, 8'hE4, 8'hE8,
    8'hD1, 8'hD2, 8'hD4, 8'hD8,
    8'hB1, 8'hB2, 8'hB4, 8'hB8,
    8'h71, 8'h72, 8'h74, 8'h78
  };

  // Row parities of din; the check value that yields a zero syndrome.
  function automatic logic [CHK_W-1:0] sec32_encode(input logic [DATA_W-1:0] din);
    logic [CHK_W-1:0] p;
    p = '0;
    for (int j = 0; j < int'(DATA_W); j++) begin
      if (din[j]) p = p ^ COL[j];
    end
    return p;
  endfunction

endpackage

// File: rtl/sec32_syndrome.sv
// Combinational syndrome: received check bits XOR recomputed row parities.
module sec32_syndrome
  import sec32_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  logic [CHK_W-1:0]  chk,
  output logic [CHK_W-1:0]  s
);

  always_comb begin
    s = chk ^ sec32_encode(din);
  end

endmodule

// File: rtl/sec32_corrector.sv
// Registered 32-bit single-error corrector: syndrome decode, one-bit flip, output register.
module sec32_corrector
  import sec32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic [CHK_W-1:0]  chk,
  input  logic              en,
  output logic [DATA_W-1:0] dout
);

  logic [CHK_W-1:0]  s;
  logic [DATA_W-1:0] flip;

  sec32_syndrome u_syndrome (
    .din (din),
    .chk (chk),
    .s   (s)
  );

  // Columns are distinct and nonzero, so at most one flip bit is set.
  always_comb begin
    flip = '0;
    for (int j = 0; j < int'(DATA_W); j++) begin
      flip[j] = en && (s == COL[j]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= '0;
    else     dout <= din ^ flip;
  end

endmodule

// File: tb/tb_sec32_corrector.sv
// Directed self-checking bench for sec32_corrector.
module tb_sec32_corrector;
  import sec32_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] din;
  logic [CHK_W-1:0]  chk;
  logic              en;
  logic [DATA_W-1:0] dout;

  int n_cmp = 0;
  int n_err = 0;

  sec32_corrector dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .chk  (chk),
    .en   (en),
    .dout (dout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [7:0] c, input logic e);
    din = d;
    chk = c;
    en  = e;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'hFFFF_FFFF, 8'h00, 1'b1);
    chk = sec32_encode(din);
    step();
    n_cmp++;
    if (dout !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold: dout=%h expected=%h", dout, 32'h0);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (dout !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL pre_reset_word: dout=%h expected=%h", dout, 32'hFFFF_FFFF);
    end
    // Mid-cycle async reset, no clock edge in between
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (dout !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: dout=%h expected=%h", dout, 32'h0);
    end
    drive(32'hA5A5_A5A5, 8'h00, 1'b1);
    chk = sec32_encode(din);
    #1 rst = 1'b0;
    step();
    n_cmp++;
    if (dout !== 32'hA5A5_A5A5) begin
      n_err++;
      $display("FAIL reset_release: dout=%h expected=%h", dout, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_clean_words();
    logic [31:0] w;
    for (int i = 0; i < 1000; i++) begin
      w = $urandom;
      drive(w, sec32_encode(w), 1'b1);
      step();
      n_cmp++;
      if (dout !== w) begin
        n_err++;
        $display("FAIL clean_word[%0d]: dout=%h expected=%h", i, dout, w);
      end
    end
  endtask

  task automatic test_single_data_error();
    logic [31:0] vec [0:2];
    logic [31:0] w;
    logic [31:0] one;
    vec[0] = 32'h0000_0001;
    vec[1] = 32'h0001_0000;
    vec[2] = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      drive(vec[i], 8'h00, 1'b1);
      step();
      n_cmp++;
      if (dout !== 32'h0) begin
        n_err++;
        $display("FAIL single_err_zero[%0d]: dout=%h expected=%h", i, dout, 32'h0);
      end
    end
    w = $urandom;
    for (int j = 0; j < 32; j++) begin
      one = 32'h1 << j;
      drive(w ^ one, sec32_encode(w), 1'b1);
      step();
      n_cmp++;
      if (dout !== w) begin
        n_err++;
        $display("FAIL single_err_sweep[%0d]: dout=%h expected=%h", j, dout, w);
      end
    end
  endtask

  task automatic test_check_bit_error();
    logic [7:0] cv [0:2];
    cv[0] = 8'h01;
    cv[1] = 8'h10;
    cv[2] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0, cv[i], 1'b1);
      step();
      n_cmp++;
      if (dout !== 32'h0) begin
        n_err++;
        $display("FAIL chk_err[%0d]: dout=%h expected=%h", i, dout, 32'h0);
      end
    end
  endtask

  task automatic test_double_error();
    drive(32'h0000_0003, 8'h00, 1'b1);
    step();
    n_cmp++;
    if (dout !== 32'h0000_0003) begin
      n_err++;
      $display("FAIL double_err: dout=%h expected=%h", dout, 32'h3);
    end
  endtask

  task automatic test_enable();
    logic        e;
    logic [31:0] exp;
    drive(32'h0000_0001, 8'h00, 1'b0);
    step();
    n_cmp++;
    if (dout !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL en_off: dout=%h expected=%h", dout, 32'h1);
    end
    for (int i = 0; i < 6; i++) begin
      e = (i % 2 == 0);
      drive(32'h0000_0001, 8'h00, e);
      exp = e ? 32'h0 : 32'h1;
      step();
      n_cmp++;
      if (dout !== exp) begin
        n_err++;
        $display("FAIL en_toggle[%0d]: dout=%h expected=%h", i, dout, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_words();
    test_single_data_error();
    test_check_bit_error();
    test_double_error();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
